fwd_hazard_unit: RTL and testbench

Parametrised successor to the EX/ID forwarding logic.
- Generates EX-operand forwarding selects for NUM_SRC sources. Store-data Rt is handled as an ordinary source.
- Generates ID-stage branch-operand (CBZ/BR) forwarding.
- Owns all pipeline interlocks: load-use, branch-after-load and multi-cycle memory waits.
- Sits beside the ID/EX/MEM/WB pipeline registers and drives their stall and bubble controls.

---
 rtl/fwd_hazard_pkg.sv | 29 ++
 rtl/fwd_match.sv | 30 +++
 rtl/fwd_hazard_unit.sv | 215 +++++++++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_hazard_pkg.sv
// Shared types for the forwarding/hazard unit: forwarding select codes,
// interlock FSM states and the per-stage match vector.
// Pure declarations, no logic, no backpressure.
package fwd_hazard_pkg;

  // Per-source EX operand select, 2 bits per source.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  // Interlock controller states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BR_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_e;

  localparam int ZERO_REG_DEFAULT = 31;

  // Which pipeline stage destinations match one register address.
  typedef struct packed {
    logic wb;
    logic mem;
    logic ex;
  } hit_t;

endpackage

// File: rtl/fwd_match.sv
// Compares one register address against the EX/MEM/WB destinations.
// Latency: combinational. Backpressure: none.
// Ports: addr/used = operand under test; *_rd/*_we = stage destinations;
//        hit = per-stage match (the zero register never matches).
module fwd_match
  import fwd_hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int ZERO_REG = ZERO_REG_DEFAULT
) (
  input  logic [REG_AW-1:0] addr,
  input  logic              used,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_we,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_we,
  output hit_t              hit
);

  localparam logic [REG_AW-1:0] ZR = REG_AW'(ZERO_REG);

  always_comb begin
    hit.ex  = used & ex_we  & (ex_rd  == addr) & (ex_rd  != ZR);
    hit.mem = used & mem_we & (mem_rd == addr) & (mem_rd != ZR);
    hit.wb  = used & wb_we  & (wb_rd  == addr) & (wb_rd  != ZR);
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX operand forwarding, ID branch-operand forwarding and all pipeline interlocks.
// Latency: forwarding and stall outputs are combinational from inputs + FSM state.
// Backpressure: drives stall_if/stall_id/bubble_ex/freeze_mem into the pipeline registers.
// Ports: ex_src_*/id_src_* = per-source operand addresses and valids; id_is_branch/
//   id_br_addr = CBZ/BR operand; {ex,mem,wb}_rd/_reg_write/_is_load = producers;
//   *_alu_result/wb_write_data = forwarding data; mem_load_valid = load data returned;
//   fwd_sel = 2b per source (00 RF, 10 MEM, 01 WB); br_fwd_* = branch override;
//   stall_cnt/fwd_cnt = statistics, live only with FWD_HAZARD_STATS_EN defined.
// All outputs are forced to 0 while rst (active-low) is asserted.
module fwd_hazard_unit
  import fwd_hazard_pkg::*;
#(
  parameter int DATA_W        = 64,
  parameter int REG_AW        = 5,
  parameter int NUM_SRC       = 3,
  parameter int ZERO_REG      = ZERO_REG_DEFAULT,
  parameter int BR_LOAD_STALL = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*REG_AW-1:0] ex_src_addr,
  input  logic [NUM_SRC-1:0]        ex_src_used,
  input  logic [NUM_SRC*REG_AW-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic                      id_is_branch,
  input  logic [REG_AW-1:0]         id_br_addr,
  input  logic [REG_AW-1:0]         ex_rd,
  input  logic [REG_AW-1:0]         mem_rd,
  input  logic [REG_AW-1:0]         wb_rd,
  input  logic                      ex_reg_write,
  input  logic                      mem_reg_write,
  input  logic                      wb_reg_write,
  input  logic                      ex_is_load,
  input  logic                      mem_is_load,
  input  logic [DATA_W-1:0]         ex_alu_result,
  input  logic [DATA_W-1:0]         mem_alu_result,
  input  logic [DATA_W-1:0]         wb_write_data,
  input  logic                      mem_load_valid,
  output logic [2*NUM_SRC-1:0]      fwd_sel,
  output logic                      br_fwd_valid,
  output logic [DATA_W-1:0]         br_fwd_data,
  output logic                      stall_if,
  output logic                      stall_id,
  output logic                      bubble_ex,
  output logic                      freeze_mem,
  output logic [31:0]               stall_cnt,
  output logic [31:0]               fwd_cnt
);

  localparam int CNT_W = (BR_LOAD_STALL > 1) ? $clog2(BR_LOAD_STALL) : 1;

  hit_t ex_hit [NUM_SRC];
  hit_t id_hit [NUM_SRC];
  hit_t br_hit;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_match #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_ex_match (
      .addr(ex_src_addr[i*REG_AW +: REG_AW]), .used(ex_src_used[i]),
      .ex_rd(ex_rd), .ex_we(ex_reg_write), .mem_rd(mem_rd), .mem_we(mem_reg_write),
      .wb_rd(wb_rd), .wb_we(wb_reg_write), .hit(ex_hit[i])
    );
    fwd_match #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_id_match (
      .addr(id_src_addr[i*REG_AW +: REG_AW]), .used(id_src_used[i]),
      .ex_rd(ex_rd), .ex_we(ex_reg_write), .mem_rd(mem_rd), .mem_we(mem_reg_write),
      .wb_rd(wb_rd), .wb_we(wb_reg_write), .hit(id_hit[i])
    );
  end

  fwd_match #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_br_match (
    .addr(id_br_addr), .used(id_is_branch),
    .ex_rd(ex_rd), .ex_we(ex_reg_write), .mem_rd(mem_rd), .mem_we(mem_reg_write),
    .wb_rd(wb_rd), .wb_we(wb_reg_write), .hit(br_hit)
  );

  // ---------------- forwarding ----------------
  logic [2*NUM_SRC-1:0] fwd_sel_raw;
  logic                 load_use;
  logic                 unused_hits;  // EX-stage hits of EX sources, MEM/WB hits of ID sources
  logic                 br_vld_raw;
  logic [DATA_W-1:0]    br_dat_raw;

  always_comb begin
    fwd_sel_raw = '0;
    load_use    = 1'b0;
    unused_hits = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ex_hit[i].mem)     fwd_sel_raw[2*i +: 2] = FWD_MEM;
      else if (ex_hit[i].wb) fwd_sel_raw[2*i +: 2] = FWD_WB;
      load_use    = load_use | (id_hit[i].ex & ex_is_load);
      unused_hits = unused_hits ^ ex_hit[i].ex ^ id_hit[i].mem ^ id_hit[i].wb;
    end
  end

  // A load producer has no data yet in EX/MEM, so those rows skip it and the
  // interlocks below cover the gap.
  always_comb begin
    br_vld_raw = 1'b0;
    br_dat_raw = '0;
    if (br_hit.ex && !ex_is_load) begin
      br_vld_raw = 1'b1;
      br_dat_raw = ex_alu_result;
    end else if (br_hit.mem && !mem_is_load) begin
      br_vld_raw = 1'b1;
      br_dat_raw = mem_alu_result;
    end else if (br_hit.wb) begin
      br_vld_raw = 1'b1;
      br_dat_raw = wb_write_data;
    end
  end

  // ---------------- interlocks ----------------
  hz_state_e        state, eff_state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic             resume_br, nxt_resume;
  logic             hz_stall, hz_bubble, hz_freeze;
  logic             mem_wait_req, br_ex_load, br_mem_load;

  assign mem_wait_req = mem_is_load & mem_reg_write & ~mem_load_valid;
  assign br_ex_load   = br_hit.ex & ex_is_load;
  assign br_mem_load  = br_hit.mem & mem_is_load;

  // The cycle the load data arrives is already handled by the state we resume to,
  // so a branch wait continues without a gap.
  always_comb begin
    eff_state = state;
    if (state == MEM_WAIT && mem_load_valid) eff_state = resume_br ? BR_WAIT : IDLE;
  end

  always_comb begin
    nxt_state  = eff_state;
    nxt_cnt    = cnt;
    nxt_resume = resume_br;
    hz_stall   = 1'b0;
    hz_bubble  = 1'b0;
    hz_freeze  = 1'b0;
    unique case (eff_state)
      MEM_WAIT: begin
        hz_freeze = 1'b1;
        hz_stall  = 1'b1;
      end
      BR_WAIT: begin
        if (mem_wait_req) begin
          hz_freeze  = 1'b1;
          hz_stall   = 1'b1;
          nxt_state  = MEM_WAIT;
          nxt_resume = 1'b1;
        end else if (cnt == '0) begin
          nxt_state = IDLE;
        end else begin
          hz_stall  = 1'b1;
          hz_bubble = 1'b1;
          nxt_cnt   = cnt - CNT_W'(1);
        end
      end
      default: begin
        if (mem_wait_req) begin
          hz_freeze  = 1'b1;
          hz_stall   = 1'b1;
          nxt_state  = MEM_WAIT;
          nxt_resume = 1'b0;
        end else if (br_ex_load) begin
          hz_stall  = 1'b1;
          hz_bubble = 1'b1;
          nxt_state = BR_WAIT;
          nxt_cnt   = CNT_W'(BR_LOAD_STALL - 1);
        end else if (br_mem_load || load_use) begin
          hz_stall  = 1'b1;
          hz_bubble = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      resume_br <= 1'b0;
    end else begin
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      resume_br <= nxt_resume;
    end
  end

  assign fwd_sel      = rst ? fwd_sel_raw : '0;
  assign br_fwd_valid = rst & br_vld_raw;
  assign br_fwd_data  = rst ? br_dat_raw : '0;
  assign stall_if     = rst & hz_stall;
  assign stall_id     = rst & hz_stall;
  assign bubble_ex    = rst & hz_bubble;
  assign freeze_mem   = rst & hz_freeze;

  // ---------------- statistics ----------------
`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] stall_q, fwd_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      fwd_q   <= '0;
    end else begin
      if (stall_id && stall_q != '1) stall_q <= stall_q + 32'd1;
      if (((|fwd_sel) || br_fwd_valid) && fwd_q != '1) fwd_q <= fwd_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign fwd_cnt   = fwd_q;
`else
  assign stall_cnt = '0;
  assign fwd_cnt   = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Randomized + directed bench for fwd_hazard_unit against a behavioural model.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
// Ends with one summary line.
`timescale 1ns/1ps
module tb_fwd_hazard_unit;
  localparam int DATA_W  = 64;
  localparam int REG_AW  = 5;
  localparam int NUM_SRC = 3;
  localparam int BRS     = 2;
  localparam int ZR      = 31;

  logic clk = 1'b0;
  logic rst;
  logic [NUM_SRC*REG_AW-1:0] ex_src_addr, id_src_addr;
  logic [NUM_SRC-1:0]        ex_src_used, id_src_used;
  logic                      id_is_branch;
  logic [REG_AW-1:0]         id_br_addr, ex_rd, mem_rd, wb_rd;
  logic ex_reg_write, mem_reg_write, wb_reg_write, ex_is_load, mem_is_load, mem_load_valid;
  logic [DATA_W-1:0]         ex_alu_result, mem_alu_result, wb_write_data;
  logic [2*NUM_SRC-1:0]      fwd_sel;
  logic                      br_fwd_valid;
  logic [DATA_W-1:0]         br_fwd_data;
  logic stall_if, stall_id, bubble_ex, freeze_mem;
  logic [31:0] stall_cnt, fwd_cnt;

  fwd_hazard_unit #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .ZERO_REG(ZR), .BR_LOAD_STALL(BRS)
  ) dut (
    .clk(clk), .rst(rst),
    .ex_src_addr(ex_src_addr), .ex_src_used(ex_src_used),
    .id_src_addr(id_src_addr), .id_src_used(id_src_used),
    .id_is_branch(id_is_branch), .id_br_addr(id_br_addr),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_reg_write(ex_reg_write), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .ex_is_load(ex_is_load), .mem_is_load(mem_is_load),
    .ex_alu_result(ex_alu_result), .mem_alu_result(mem_alu_result), .wb_write_data(wb_write_data),
    .mem_load_valid(mem_load_valid),
    .fwd_sel(fwd_sel), .br_fwd_valid(br_fwd_valid), .br_fwd_data(br_fwd_data),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex), .freeze_mem(freeze_mem),
    .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state: waiting on load data, branch-wait in progress, stall cycles still owed.
  bit              m_blocked;
  bit              m_br_active;
  int              m_owed;
  longint unsigned m_stall_n, m_fwd_n;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit hit(input logic [REG_AW-1:0] a, input logic used,
                             input logic [REG_AW-1:0] rd, input logic we);
    return used && we && (rd == a) && (int'(rd) != ZR);
  endfunction

  task automatic model_reset();
    m_blocked   = 0;
    m_br_active = 0;
    m_owed      = 0;
    m_stall_n   = 0;
    m_fwd_n     = 0;
  endtask

  task automatic idle();
    ex_src_addr = '0; ex_src_used = '0; id_src_addr = '0; id_src_used = '0;
    id_is_branch = 0; id_br_addr = '0;
    ex_rd = '0; mem_rd = '0; wb_rd = '0;
    ex_reg_write = 0; mem_reg_write = 0; wb_reg_write = 0;
    ex_is_load = 0; mem_is_load = 0; mem_load_valid = 1;
    ex_alu_result  = {$urandom, $urandom};
    mem_alu_result = {$urandom, $urandom};
    wb_write_data  = {$urandom, $urandom};
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Wait for negedge, compare every output against the model, then advance the model.
  task automatic cyc();
    logic [2*NUM_SRC-1:0] e_sel;
    logic                 e_brv;
    logic [DATA_W-1:0]    e_brd;
    logic [REG_AW-1:0]    ea, ia;
    bit e_frz, e_st, e_bub, lu, bel, bml;
    @(negedge clk);
    e_sel = '0;
    lu    = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      ea = ex_src_addr[i*REG_AW +: REG_AW];
      ia = id_src_addr[i*REG_AW +: REG_AW];
      if (hit(ea, ex_src_used[i], mem_rd, mem_reg_write))     e_sel[2*i +: 2] = 2'b10;
      else if (hit(ea, ex_src_used[i], wb_rd, wb_reg_write))  e_sel[2*i +: 2] = 2'b01;
      if (ex_is_load && hit(ia, id_src_used[i], ex_rd, ex_reg_write)) lu = 1;
    end
    e_brv = 0;
    e_brd = '0;
    if (!ex_is_load && hit(id_br_addr, id_is_branch, ex_rd, ex_reg_write)) begin
      e_brv = 1; e_brd = ex_alu_result;
    end else if (!mem_is_load && hit(id_br_addr, id_is_branch, mem_rd, mem_reg_write)) begin
      e_brv = 1; e_brd = mem_alu_result;
    end else if (hit(id_br_addr, id_is_branch, wb_rd, wb_reg_write)) begin
      e_brv = 1; e_brd = wb_write_data;
    end
    bel = ex_is_load && hit(id_br_addr, id_is_branch, ex_rd, ex_reg_write);
    bml = mem_is_load && hit(id_br_addr, id_is_branch, mem_rd, mem_reg_write);

    e_frz = m_blocked ? !mem_load_valid : (mem_is_load && mem_reg_write && !mem_load_valid);
    e_st  = 0;
    e_bub = 0;
    if (e_frz) begin
      e_st = 1;
    end else if (m_br_active) begin
      if (m_owed == 0) m_br_active = 0;
      else begin e_st = 1; e_bub = 1; m_owed--; end
    end else if (bel) begin
      e_st = 1; e_bub = 1; m_br_active = 1; m_owed = BRS - 1;
    end else if (bml || lu) begin
      e_st = 1; e_bub = 1;
    end
    m_blocked = e_frz;

    chk("fwd_sel",      64'(fwd_sel),      64'(e_sel));
    chk("br_fwd_valid", 64'(br_fwd_valid), 64'(e_brv));
    chk("br_fwd_data",  64'(br_fwd_data),  64'(e_brd));
    chk("stall_if",     64'(stall_if),     64'(e_st));
    chk("stall_id",     64'(stall_id),     64'(e_st));
    chk("bubble_ex",    64'(bubble_ex),    64'(e_bub));
    chk("freeze_mem",   64'(freeze_mem),   64'(e_frz));
`ifdef FWD_HAZARD_STATS_EN
    chk("stall_cnt", 64'(stall_cnt), m_stall_n);
    chk("fwd_cnt",   64'(fwd_cnt),   m_fwd_n);
    if (e_st && m_stall_n < 64'hFFFF_FFFF) m_stall_n++;
    if ((e_sel != '0 || e_brv) && m_fwd_n < 64'hFFFF_FFFF) m_fwd_n++;
`else
    chk("stall_cnt_tied", 64'(stall_cnt), 64'd0);
    chk("fwd_cnt_tied",   64'(fwd_cnt),   64'd0);
`endif
  endtask

  function automatic logic [REG_AW-1:0] rreg();
    case ($urandom_range(0, 3))
      0:       return 5'd3;
      1:       return 5'd9;
      2:       return 5'd31;
      default: return 5'd12;
    endcase
  endfunction

  task automatic rand_inputs();
    for (int i = 0; i < NUM_SRC; i++) begin
      ex_src_addr[i*REG_AW +: REG_AW] = rreg();
      id_src_addr[i*REG_AW +: REG_AW] = rreg();
    end
    ex_src_used    = 3'($urandom_range(0, 7));
    id_src_used    = 3'($urandom_range(0, 7));
    id_is_branch   = ($urandom_range(0, 1) == 1);
    id_br_addr     = rreg();
    ex_rd          = rreg();
    mem_rd         = rreg();
    wb_rd          = rreg();
    ex_reg_write   = ($urandom_range(0, 3) != 0);
    mem_reg_write  = ($urandom_range(0, 3) != 0);
    wb_reg_write   = ($urandom_range(0, 3) != 0);
    ex_is_load     = ($urandom_range(0, 2) == 0);
    mem_is_load    = ($urandom_range(0, 2) == 0);
    mem_load_valid = ($urandom_range(0, 3) != 0);
    ex_alu_result  = {$urandom, $urandom};
    mem_alu_result = {$urandom, $urandom};
    wb_write_data  = {$urandom, $urandom};
  endtask

  int n, nf;

  initial begin
    // ---- reset: outputs must be 0 even with hazards/matches on the inputs ----
    idle();
    rst = 1;
    #1 rst = 0;
    model_reset();
    ex_src_addr[0 +: REG_AW] = 5; ex_src_used = 3'b001; mem_rd = 5; mem_reg_write = 1;
    ex_is_load = 1; ex_rd = 3; ex_reg_write = 1;
    id_src_addr[0 +: REG_AW] = 3; id_src_used = 3'b001;
    #2;
    chk("rst_fwd_sel",   64'(fwd_sel),   64'd0);
    chk("rst_stall_id",  64'(stall_id),  64'd0);
    chk("rst_bubble_ex", 64'(bubble_ex), 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("rst_fwd_cnt",   64'(fwd_cnt),   64'd0);
    adv(); adv();
    rst = 1;
    idle();

    // ---- 1: MEM beats WB; zero-register MEM falls back to WB ----
    ex_src_addr[0 +: REG_AW] = 5; ex_src_used = 3'b001;
    mem_rd = 5; mem_reg_write = 1; wb_rd = 5; wb_reg_write = 1;
    cyc(); chk("t1_mem_wins", 64'(fwd_sel[1:0]), 64'd2); adv();
    mem_rd = 31;
    cyc(); chk("t1_wb_when_mem_zr", 64'(fwd_sel[1:0]), 64'd1); adv();

    // ---- 2: store Rt as source 2 ----
    idle();
    ex_src_addr[2*REG_AW +: REG_AW] = 7; ex_src_used = 3'b100; wb_rd = 7; wb_reg_write = 1;
    cyc(); chk("t2_rt_wb", 64'(fwd_sel[5:4]), 64'd1); adv();
    wb_rd = 31;
    cyc(); chk("t2_rt_zr", 64'(fwd_sel[5:4]), 64'd0); adv();

    // ---- 3: load-use, one stall cycle then WB forward ----
    idle();
    ex_is_load = 1; ex_rd = 3; ex_reg_write = 1;
    id_src_addr[REG_AW +: REG_AW] = 3; id_src_used = 3'b010;
    cyc();
    chk("t3_stall_if", 64'(stall_if), 64'd1);
    chk("t3_stall_id", 64'(stall_id), 64'd1);
    chk("t3_bubble",   64'(bubble_ex), 64'd1);
    adv();
    idle();
    ex_src_addr[REG_AW +: REG_AW] = 3; ex_src_used = 3'b010; wb_rd = 3; wb_reg_write = 1;
    cyc();
    chk("t3_no_stall", 64'(stall_id), 64'd0);
    chk("t3_fwd_wb",   64'(fwd_sel[3:2]), 64'd1);
    adv();

    // ---- 4: CBZ after LDUR: two stall cycles, then WB forward ----
    idle();
    wb_write_data = 64'h0123_4567_89ab_cdef;
    ex_is_load = 1; ex_rd = 9; ex_reg_write = 1; id_is_branch = 1; id_br_addr = 9;
    n = 0;
    cyc(); if (stall_id) n++; adv();
    ex_is_load = 0; ex_reg_write = 0;
    mem_is_load = 1; mem_rd = 9; mem_reg_write = 1; mem_load_valid = 1;
    cyc(); if (stall_id) n++; adv();
    mem_is_load = 0; mem_reg_write = 0; wb_rd = 9; wb_reg_write = 1;
    cyc(); if (stall_id) n++;
    chk("t4_br_fwd_valid", 64'(br_fwd_valid), 64'd1);
    chk("t4_br_fwd_data",  64'(br_fwd_data),  64'h0123_4567_89ab_cdef);
    adv();
    chk("t4_stall_cycles", 64'(n), 64'd2);

    // ---- 5a: load data late for 3 cycles ----
    idle();
    mem_is_load = 1; mem_reg_write = 1; mem_rd = 4;
    nf = 0;
    for (int k = 0; k < 5; k++) begin
      mem_load_valid = (k >= 3);
      cyc(); if (freeze_mem) nf++; adv();
    end
    chk("t5_freeze_cycles", 64'(nf), 64'd3);

    // ---- 5b: memory wait raised during a branch wait ----
    idle();
    wb_write_data = 64'hfeed_face_cafe_beef;
    ex_is_load = 1; ex_rd = 9; ex_reg_write = 1; id_is_branch = 1; id_br_addr = 9;
    n = 0; nf = 0;
    cyc(); if (stall_id) n++; adv();
    ex_is_load = 0; ex_reg_write = 0;
    mem_is_load = 1; mem_rd = 9; mem_reg_write = 1;
    for (int k = 0; k < 4; k++) begin
      mem_load_valid = (k == 3);
      cyc(); if (stall_id) n++; if (freeze_mem) nf++; adv();
    end
    mem_is_load = 0; mem_reg_write = 0; wb_rd = 9; wb_reg_write = 1;
    cyc(); if (stall_id) n++;
    chk("t5_br_fwd_wb", 64'(br_fwd_data), 64'hfeed_face_cafe_beef);
    adv();
    idle();
    cyc(); if (stall_id) n++; adv();
    chk("t5_br_stall_total", 64'(n), 64'd5);
    chk("t5_br_freeze",      64'(nf), 64'd3);

    // ---- random traffic ----
    for (int c = 0; c < 1500; c++) begin
      rand_inputs();
      cyc();
      adv();
    end

    // ---- 6: reset in the middle of a branch wait ----
    idle();
    ex_is_load = 1; ex_rd = 9; ex_reg_write = 1; id_is_branch = 1; id_br_addr = 9;
    cyc(); adv();
    ex_is_load = 0; ex_reg_write = 0;
    mem_is_load = 1; mem_rd = 9; mem_reg_write = 1; mem_load_valid = 1;
    wb_rd = 9; wb_reg_write = 1;
    ex_src_addr[0 +: REG_AW] = 9; ex_src_used = 3'b001;
    rst = 0;
    #1;
    chk("t6_stall_id",     64'(stall_id),     64'd0);
    chk("t6_stall_if",     64'(stall_if),     64'd0);
    chk("t6_bubble_ex",    64'(bubble_ex),    64'd0);
    chk("t6_fwd_sel",      64'(fwd_sel),      64'd0);
    chk("t6_br_fwd_valid", 64'(br_fwd_valid), 64'd0);
    chk("t6_stall_cnt",    64'(stall_cnt),    64'd0);
    model_reset();
    idle();
    id_is_branch = 1; id_br_addr = 9;
    #1 rst = 1;
    cyc(); chk("t6_idle_after_rst", 64'(stall_id), 64'd0); adv();

    for (int c = 0; c < 300; c++) begin
      rand_inputs();
      cyc();
      adv();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
